// File: rtl/pong_pkg.sv
// Shared pong constants and the Y-position updater state encoding.
// Default sizes match the checkers that consume the positions.
package pong_pkg;

  localparam int SCREEN_HEIGHT_D     = 480;
  localparam int PLAYER_HEIGHT_LOG_D = 9;
  localparam int PLAYER_LEN_D        = 64;
  localparam int BALL_HEIGHT_LOG_D   = 9;
  localparam int BALL_PIXSIZE_D      = 8;
  localparam int PLAYER_SPEED_D      = 4;
  localparam int BALL_SPEED_Y_D      = 2;
  localparam int MAX_BALL_SPEED_Y_D  = 6;

  localparam int YPU_IDLE     = 0;
  localparam int YPU_SAMPLE   = 1;
  localparam int YPU_UPD_P1   = 2;
  localparam int YPU_UPD_P2   = 3;
  localparam int YPU_UPD_BALL = 4;
  localparam int YPU_WAIT_LOW = 5;
  localparam int YPU_N        = 6;

  typedef enum logic [YPU_N-1:0] {
    S_IDLE     = YPU_N'(1 << YPU_IDLE),
    S_SAMPLE   = YPU_N'(1 << YPU_SAMPLE),
    S_UPD_P1   = YPU_N'(1 << YPU_UPD_P1),
    S_UPD_P2   = YPU_N'(1 << YPU_UPD_P2),
    S_UPD_BALL = YPU_N'(1 << YPU_UPD_BALL),
    S_WAIT_LOW = YPU_N'(1 << YPU_WAIT_LOW)
  } ypu_state_e;

endpackage

// File: rtl/pong_y_pos_updater_paddle_stepper.sv
// pong_paddle_stepper: one frame of paddle motion, clamped to screen.
// Both or neither button pressed leaves the paddle where it is.
module pong_paddle_stepper #(
  parameter int PLAYER_HEIGHT_LOG = 9,
  parameter int PLAYER_LEN        = 64,
  parameter int SCREEN_HEIGHT     = 480,
  parameter int PLAYER_SPEED      = 4
) (
  input  logic [PLAYER_HEIGHT_LOG-1:0] pos,
  input  logic                         up,
  input  logic                         down,
  output logic [PLAYER_HEIGHT_LOG-1:0] nextPos
);

  localparam int W = PLAYER_HEIGHT_LOG + 1;
  localparam logic [W-1:0] PMAX = W'(SCREEN_HEIGHT - PLAYER_LEN);
  localparam logic [W-1:0] SPD  = W'(PLAYER_SPEED);

  logic [W-1:0] posW;
  logic [W-1:0] sum;

  // Extra headroom bit keeps the down-sum from wrapping before the clamp.
  always_comb begin
    posW    = {1'b0, pos};
    sum     = posW + SPD;
    nextPos = pos;
    if (up && !down) begin
      nextPos = (posW < SPD) ? '0 : PLAYER_HEIGHT_LOG'(posW - SPD);
    end else if (down && !up) begin
      nextPos = (sum > PMAX) ? PLAYER_HEIGHT_LOG'(PMAX)
                             : PLAYER_HEIGHT_LOG'(sum);
    end
  end

endmodule

// File: rtl/pong_y_pos_updater.sv
// Per-frame Y-position producer: paddles, ball, bounce and serve.
// Optional macro PONG_BALL_SPEEDUP_EN: ball speeds up on each bounce.
module pong_y_pos_updater
  import pong_pkg::*;
#(
  parameter int SCREEN_HEIGHT     = SCREEN_HEIGHT_D,
  parameter int PLAYER_HEIGHT_LOG = PLAYER_HEIGHT_LOG_D,
  parameter int PLAYER_LEN        = PLAYER_LEN_D,
  parameter int BALL_HEIGHT_LOG   = BALL_HEIGHT_LOG_D,
  parameter int BALL_PIXSIZE      = BALL_PIXSIZE_D,
  parameter int PLAYER_SPEED      = PLAYER_SPEED_D,
  parameter int BALL_SPEED_Y      = BALL_SPEED_Y_D,
  parameter int MAX_BALL_SPEED_Y  = MAX_BALL_SPEED_Y_D
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         V_BLANK,
  input  logic                         P1_UP,
  input  logic                         P1_DOWN,
  input  logic                         P2_UP,
  input  logic                         P2_DOWN,
  input  logic                         SERVE,
  output logic [BALL_HEIGHT_LOG-1:0]   ballYPos,
  output logic [PLAYER_HEIGHT_LOG-1:0] player1Pos,
  output logic [PLAYER_HEIGHT_LOG-1:0] player2Pos,
  output logic                         ballDirDown,
  output logic                         FRAME_DONE
);

  localparam int BW = BALL_HEIGHT_LOG + 1;
  localparam logic [BW-1:0] BMAX = BW'(SCREEN_HEIGHT - BALL_PIXSIZE);
  localparam logic [BALL_HEIGHT_LOG-1:0] BCENTER =
    BALL_HEIGHT_LOG'((SCREEN_HEIGHT - BALL_PIXSIZE) / 2);
  localparam logic [PLAYER_HEIGHT_LOG-1:0] PCENTER =
    PLAYER_HEIGHT_LOG'((SCREEN_HEIGHT - PLAYER_LEN) / 2);

  ypu_state_e state;
  logic       vBlankBuf;
  logic       vbRise;
  logic [3:0] btn;
  logic       serveLatch;
  logic       serveNow;

  logic [PLAYER_HEIGHT_LOG-1:0] nextP1;
  logic [PLAYER_HEIGHT_LOG-1:0] nextP2;

  logic [BW-1:0]              spd;
  logic [BW-1:0]              bPosW;
  logic [BW-1:0]              bSum;
  logic [BALL_HEIGHT_LOG-1:0] bNext;
  logic                       bDirNext;
  logic                       bBounce;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [BW-1:0] speed;
  assign spd = speed;
`else
  assign spd = BW'(BALL_SPEED_Y);
`endif

  assign vbRise   = V_BLANK && !vBlankBuf;
  assign serveNow = serveLatch || SERVE;

  pong_paddle_stepper #(
    .PLAYER_HEIGHT_LOG(PLAYER_HEIGHT_LOG),
    .PLAYER_LEN       (PLAYER_LEN),
    .SCREEN_HEIGHT    (SCREEN_HEIGHT),
    .PLAYER_SPEED     (PLAYER_SPEED)
  ) u_step1 (
    .pos    (player1Pos),
    .up     (btn[0]),
    .down   (btn[1]),
    .nextPos(nextP1)
  );

  pong_paddle_stepper #(
    .PLAYER_HEIGHT_LOG(PLAYER_HEIGHT_LOG),
    .PLAYER_LEN       (PLAYER_LEN),
    .SCREEN_HEIGHT    (SCREEN_HEIGHT),
    .PLAYER_SPEED     (PLAYER_SPEED)
  ) u_step2 (
    .pos    (player2Pos),
    .up     (btn[2]),
    .down   (btn[3]),
    .nextPos(nextP2)
  );

  // Next ball position: a pending serve overrides motion and bounce.
  always_comb begin
    bPosW    = {1'b0, ballYPos};
    bSum     = bPosW + spd;
    bNext    = ballYPos;
    bDirNext = ballDirDown;
    bBounce  = 1'b0;
    if (serveNow) begin
      bNext = BCENTER;
    end else if (ballDirDown) begin
      if (bSum >= BMAX) begin
        bNext    = BALL_HEIGHT_LOG'(BMAX);
        bDirNext = 1'b0;
        bBounce  = 1'b1;
      end else begin
        bNext = BALL_HEIGHT_LOG'(bSum);
      end
    end else begin
      if (bPosW <= spd) begin
        bNext    = '0;
        bDirNext = 1'b1;
        bBounce  = 1'b1;
      end else begin
        bNext = BALL_HEIGHT_LOG'(bPosW - spd);
      end
    end
  end

  // Update sequencer; outputs move only in the three UPD states.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      vBlankBuf   <= 1'b1;
      btn         <= '0;
      serveLatch  <= 1'b0;
      player1Pos  <= PCENTER;
      player2Pos  <= PCENTER;
      ballYPos    <= BCENTER;
      ballDirDown <= 1'b1;
      FRAME_DONE  <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
      speed       <= BW'(BALL_SPEED_Y);
`endif
    end else begin
      vBlankBuf  <= V_BLANK;
      FRAME_DONE <= 1'b0;
      if (SERVE) serveLatch <= 1'b1;
      unique case (1'b1)
        state[YPU_IDLE]: begin
          if (vbRise) state <= S_SAMPLE;
        end
        state[YPU_SAMPLE]: begin
          btn   <= {P2_DOWN, P2_UP, P1_DOWN, P1_UP};
          state <= S_UPD_P1;
        end
        state[YPU_UPD_P1]: begin
          player1Pos <= nextP1;
          state      <= S_UPD_P2;
        end
        state[YPU_UPD_P2]: begin
          player2Pos <= nextP2;
          state      <= S_UPD_BALL;
        end
        state[YPU_UPD_BALL]: begin
          ballYPos    <= bNext;
          ballDirDown <= bDirNext;
          serveLatch  <= 1'b0;
          FRAME_DONE  <= 1'b1;
          state       <= S_WAIT_LOW;
`ifdef PONG_BALL_SPEEDUP_EN
          if (serveNow) begin
            speed <= BW'(BALL_SPEED_Y);
          end else if (bBounce && speed < BW'(MAX_BALL_SPEED_Y)) begin
            speed <= speed + 1'b1;
          end
`endif
        end
        state[YPU_WAIT_LOW]: begin
          if (!V_BLANK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
